// File: rtl/snd_arb.sv
// Sound-request arbiter: one pending slot per requester, fixed-priority issue
// to the sound manager over a trig/playing handshake with a silence gap.
module snd_arb #(
  parameter int ACK_TIMEOUT = 15,
  parameter int GAP_CYCLES  = 1000
) (
  input  logic        i_clk_1mhz,
  input  logic        i_rst,
  input  logic [3:0]  i_req,
  input  logic [11:0] i_req_mode,
  input  logic        i_flush,
  input  logic        i_snd_playing,
  output logic        o_snd_trig,
  output logic [2:0]  o_snd_mode,
  output logic [3:0]  o_grant,
  output logic [3:0]  o_drop,
  output logic        o_timeout,
  output logic        o_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_PLAYING,
    S_GAP
  } state_t;

  localparam logic [7:0]  ACK_LAST = 8'(ACK_TIMEOUT);
  // GAP lasts GAP_CYCLES cycles, but never less than one
  localparam logic [15:0] GAP_LAST = (GAP_CYCLES == 0) ? 16'd0 : 16'(GAP_CYCLES - 1);

  state_t          r_state;
  logic [3:0]      r_pend_v;
  logic [3:0][2:0] r_pend_m;
  logic [7:0]      r_ack_cnt;
  logic [15:0]     r_gap_cnt;

  logic            w_win;
  logic [3:0]      w_sel;
  logic [2:0]      w_sel_mode;
  logic [3:0]      w_req_ok;
  logic [3:0]      w_pend_v_nxt;
  logic [3:0][2:0] w_pend_m_nxt;
  logic [3:0]      w_drop_nxt;

  // Lowest set pending index wins
  always_comb begin
    w_sel      = r_pend_v & (~r_pend_v + 4'd1);
    w_sel_mode = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (w_sel[i]) w_sel_mode = r_pend_m[i];
    end
    w_win = (r_state == S_IDLE) && (|r_pend_v) && !i_snd_playing && !i_flush;
  end

  // Slot update: a grant frees its slot before a same-cycle request refills it
  always_comb begin
    w_pend_v_nxt = r_pend_v;
    w_pend_m_nxt = r_pend_m;
    w_drop_nxt   = 4'd0;
    w_req_ok     = 4'd0;
    for (int i = 0; i < 4; i++) begin
      w_req_ok[i] = i_req[i] && (i_req_mode[3*i +: 3] != 3'd0);
      if (i_flush) begin
        w_drop_nxt[i]   = r_pend_v[i] | w_req_ok[i];
        w_pend_v_nxt[i] = 1'b0;
      end else begin
        if (w_win && w_sel[i]) w_pend_v_nxt[i] = 1'b0;
        if (w_req_ok[i]) begin
          w_drop_nxt[i]   = r_pend_v[i] && !(w_win && w_sel[i]);
          w_pend_v_nxt[i] = 1'b1;
          w_pend_m_nxt[i] = i_req_mode[3*i +: 3];
        end
      end
    end
  end

  always_ff @(posedge i_clk_1mhz) begin
    r_pend_m <= w_pend_m_nxt;
  end

  always_ff @(posedge i_clk_1mhz) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_pend_v   <= 4'd0;
      r_ack_cnt  <= 8'd0;
      r_gap_cnt  <= 16'd0;
      o_snd_trig <= 1'b0;
      o_snd_mode <= 3'd0;
      o_grant    <= 4'd0;
      o_drop     <= 4'd0;
      o_timeout  <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      r_pend_v   <= w_pend_v_nxt;
      o_drop     <= w_drop_nxt;
      o_grant    <= 4'd0;
      o_snd_trig <= 1'b0;
      o_timeout  <= 1'b0;
      o_busy     <= |w_pend_v_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_win) begin
            o_grant    <= w_sel;
            o_snd_mode <= w_sel_mode;
            o_busy     <= 1'b1;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          o_snd_trig <= 1'b1;
          r_ack_cnt  <= 8'd0;
          o_busy     <= 1'b1;
          r_state    <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          o_busy <= 1'b1;
          if (i_snd_playing) begin
            r_state <= S_PLAYING;
          end else begin
            r_ack_cnt <= r_ack_cnt + 8'd1;
            if (r_ack_cnt + 8'd1 == ACK_LAST) begin
              o_timeout <= 1'b1;
              r_gap_cnt <= 16'd0;
              r_state   <= S_GAP;
            end
          end
        end
        S_PLAYING: begin
          o_busy <= 1'b1;
          if (!i_snd_playing) begin
            r_gap_cnt <= 16'd0;
            r_state   <= S_GAP;
          end
        end
        S_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_state <= S_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 16'd1;
            o_busy    <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snd_arb.sv
// Bench for snd_arb: directed scenarios plus random traffic, every cycle
// compared against a timestamp-based reference model of the arbiter.
module tb_snd_arb;

  localparam int ACK_T = 15;
  localparam int GAP   = 8;
  localparam int NEVER = 1000000;
  localparam int P_IDLE = 0, P_ISSUE = 1, P_WAIT = 2, P_PLAY = 3, P_GAP = 4;

  logic        clk;
  logic        i_rst;
  logic [3:0]  i_req;
  logic [11:0] i_req_mode;
  logic        i_flush;
  logic        i_snd_playing;
  logic        o_snd_trig;
  logic [2:0]  o_snd_mode;
  logic [3:0]  o_grant;
  logic [3:0]  o_drop;
  logic        o_timeout;
  logic        o_busy;

  snd_arb #(.ACK_TIMEOUT(ACK_T), .GAP_CYCLES(GAP)) dut (
    .i_clk_1mhz   (clk),
    .i_rst        (i_rst),
    .i_req        (i_req),
    .i_req_mode   (i_req_mode),
    .i_flush      (i_flush),
    .i_snd_playing(i_snd_playing),
    .o_snd_trig   (o_snd_trig),
    .o_snd_mode   (o_snd_mode),
    .o_grant      (o_grant),
    .o_drop       (o_drop),
    .o_timeout    (o_timeout),
    .o_busy       (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // reference model state
  bit   m_pv[4];
  int   m_pm[4];
  int   m_phase = P_IDLE;
  int   m_wait_start = 0;
  int   m_gap_end = 0;
  logic [3:0] e_grant, e_drop;
  logic       e_trig, e_timeout, e_busy;
  logic [2:0] e_mode;

  // sound-manager stand-in and observation logs
  int s_rise = 0, s_fall = 0;
  int force_d = -1, force_len = 0;
  int g_log[$];
  int n_to = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [11:0] mk(input int i, input int m);
    logic [11:0] v;
    v = 12'd0;
    v[3*i +: 3] = 3'(m);
    return v;
  endfunction

  function automatic bit sndm_level(input int t);
    return (t >= s_rise) && (t < s_fall);
  endfunction

  task automatic model_step(input logic [3:0] req, input logic [11:0] modes,
                            input logic flush, input logic play, input logic rst);
    int k;
    bit any;
    int md;
    e_grant = 4'd0; e_drop = 4'd0; e_trig = 1'b0; e_timeout = 1'b0;
    if (rst) begin
      for (int i = 0; i < 4; i++) m_pv[i] = 1'b0;
      m_phase = P_IDLE;
      e_mode = 3'd0;
      e_busy = 1'b0;
      return;
    end
    k = -1;
    any = 1'b0;
    for (int i = 0; i < 4; i++) any |= m_pv[i];
    if (m_phase == P_IDLE && any && !play && !flush) begin
      for (int i = 3; i >= 0; i--) if (m_pv[i]) k = i;
      e_grant[k] = 1'b1;
      e_mode = 3'(m_pm[k]);
      m_pv[k] = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      md = int'((modes >> (3*i)) & 12'h7);
      if (flush) begin
        if (m_pv[i] || (req[i] && md != 0)) e_drop[i] = 1'b1;
        m_pv[i] = 1'b0;
      end else if (req[i] && md != 0) begin
        if (m_pv[i]) e_drop[i] = 1'b1;
        m_pv[i] = 1'b1;
        m_pm[i] = md;
      end
    end
    case (m_phase)
      P_IDLE:  if (k >= 0) m_phase = P_ISSUE;
      P_ISSUE: begin e_trig = 1'b1; m_wait_start = cyc; m_phase = P_WAIT; end
      P_WAIT: begin
        if (play) m_phase = P_PLAY;
        else if (cyc - m_wait_start == ACK_T) begin
          e_timeout = 1'b1;
          m_gap_end = cyc + ((GAP > 0) ? GAP : 1);
          m_phase = P_GAP;
        end
      end
      P_PLAY: if (!play) begin m_gap_end = cyc + ((GAP > 0) ? GAP : 1); m_phase = P_GAP; end
      default: if (cyc == m_gap_end) m_phase = P_IDLE;
    endcase
    any = 1'b0;
    for (int i = 0; i < 4; i++) any |= m_pv[i];
    e_busy = (m_phase != P_IDLE) || any;
  endtask

  task automatic cycle(input logic [3:0] req, input logic [11:0] modes,
                       input logic flush, input logic rst);
    int d, r;
    i_req = req; i_req_mode = modes; i_flush = flush; i_rst = rst;
    i_snd_playing = sndm_level(cyc + 1);
    @(posedge clk);
    cyc++;
    model_step(req, modes, flush, i_snd_playing, rst);
    #1;
    check("grant",   32'(o_grant),    32'(e_grant));
    check("drop",    32'(o_drop),     32'(e_drop));
    check("trig",    32'(o_snd_trig), 32'(e_trig));
    check("timeout", 32'(o_timeout),  32'(e_timeout));
    check("mode",    32'(o_snd_mode), 32'(e_mode));
    check("busy",    32'(o_busy),     32'(e_busy));
    if (o_grant != 4'd0) g_log.push_back(int'(o_grant) * 16 + int'(o_snd_mode));
    if (o_timeout) n_to++;
    if (o_snd_trig) begin
      if (force_d >= 0) d = force_d;
      else begin
        r = int'($urandom_range(0, 7));
        d = (r < 4) ? r : (r == 4) ? 13 : (r == 5) ? 14 : (r == 6) ? 15 : NEVER;
      end
      s_rise = cyc + 1 + d;
      s_fall = s_rise + ((force_len > 0) ? force_len : int'($urandom_range(1, 25)));
    end
    i_req = 4'd0; i_flush = 1'b0; i_rst = 1'b0;
  endtask

  task automatic wait_playing(input int max);
    int n;
    n = 0;
    while (!sndm_level(cyc + 1) && n < max) begin cycle(4'd0, 12'd0, 1'b0, 1'b0); n++; end
    check("wait_play", 32'(sndm_level(cyc + 1)), 32'd1);
  endtask

  task automatic run_idle(input int max);
    int n;
    n = 0;
    while ((o_busy || sndm_level(cyc + 1)) && n < max) begin
      cycle(4'd0, 12'd0, 1'b0, 1'b0);
      n++;
    end
    check("idle_reach", 32'(o_busy), 32'd0);
  endtask

  initial begin
    i_rst = 1'b0; i_req = 4'd0; i_req_mode = 12'd0; i_flush = 1'b0; i_snd_playing = 1'b0;
    for (int i = 0; i < 4; i++) begin m_pv[i] = 1'b0; m_pm[i] = 0; end

    // reset
    repeat (3) cycle(4'd0, 12'd0, 1'b0, 1'b1);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_mode", 32'(o_snd_mode), 32'd0);

    // single request, playing 2 cycles after trig for 50 cycles
    force_d = 1; force_len = 50;
    g_log.delete();
    cycle(4'b0001, mk(0, 3), 1'b0, 1'b0);
    check("sgl_nogrant", 32'(o_grant), 32'd0);
    cycle(4'd0, 12'd0, 1'b0, 1'b0);
    check("sgl_grant", 32'(o_grant), 32'h1);
    check("sgl_mode", 32'(o_snd_mode), 32'd3);
    cycle(4'd0, 12'd0, 1'b0, 1'b0);
    check("sgl_trig", 32'(o_snd_trig), 32'd1);
    cycle(4'd0, 12'd0, 1'b0, 1'b0);
    check("sgl_trig_end", 32'(o_snd_trig), 32'd0);
    run_idle(500);
    check("sgl_idle_at", 32'(cyc - s_fall), 32'(GAP));

    // priority and overwrite
    force_len = 20;
    g_log.delete();
    cycle(4'b0100, mk(2, 7), 1'b0, 1'b0);
    wait_playing(50);
    cycle(4'b1010, mk(1, 4) | mk(3, 1), 1'b0, 1'b0);
    check("pri_nodrop", 32'(o_drop), 32'd0);
    cycle(4'b1000, mk(3, 6), 1'b0, 1'b0);
    check("pri_drop3", 32'(o_drop), 32'h8);
    run_idle(800);
    check("pri_n", 32'(g_log.size()), 32'd3);
    if (g_log.size() == 3) begin
      check("pri_g0", 32'(g_log[0]), 32'h47);
      check("pri_g1", 32'(g_log[1]), 32'h24);
      check("pri_g2", 32'(g_log[2]), 32'h86);
    end

    // ack timeout: playing never rises
    force_d = NEVER;
    g_log.delete(); n_to = 0;
    cycle(4'b0101, mk(0, 3) | mk(2, 5), 1'b0, 1'b0);
    run_idle(500);
    check("to_count", 32'(n_to), 32'd2);
    check("to_n", 32'(g_log.size()), 32'd2);
    if (g_log.size() == 2) begin
      check("to_g0", 32'(g_log[0]), 32'h13);
      check("to_g1", 32'(g_log[1]), 32'h45);
    end

    // flush during a sound
    force_d = 1; force_len = 30;
    g_log.delete();
    cycle(4'b1000, mk(3, 1), 1'b0, 1'b0);
    wait_playing(50);
    cycle(4'b0101, mk(0, 2) | mk(2, 3), 1'b0, 1'b0);
    cycle(4'b0010, mk(1, 4), 1'b1, 1'b0);
    check("fl_drop", 32'(o_drop), 32'h7);
    check("fl_grant", 32'(o_grant), 32'd0);
    check("fl_busy", 32'(o_busy), 32'd1);
    run_idle(500);
    check("fl_n", 32'(g_log.size()), 32'd1);

    // request collides with its own grant
    force_len = 5;
    g_log.delete();
    cycle(4'b0001, mk(0, 5), 1'b0, 1'b0);
    cycle(4'b0001, mk(0, 2), 1'b0, 1'b0);
    check("col_grant", 32'(o_grant), 32'h1);
    check("col_mode", 32'(o_snd_mode), 32'd5);
    check("col_drop", 32'(o_drop), 32'd0);
    run_idle(500);
    check("col_n", 32'(g_log.size()), 32'd2);
    if (g_log.size() == 2) begin
      check("col_g0", 32'(g_log[0]), 32'h15);
      check("col_g1", 32'(g_log[1]), 32'h12);
    end

    // reset mid-sound; sound manager keeps playing on its own
    force_len = 40;
    cycle(4'b0001, mk(0, 6), 1'b0, 1'b0);
    wait_playing(50);
    cycle(4'b0010, mk(1, 2), 1'b0, 1'b0);
    repeat (3) cycle(4'd0, 12'd0, 1'b0, 1'b1);
    check("rstm_busy", 32'(o_busy), 32'd0);
    check("rstm_mode", 32'(o_snd_mode), 32'd0);
    check("rstm_play", 32'(sndm_level(cyc + 1)), 32'd1);
    cycle(4'b0001, mk(0, 4), 1'b0, 1'b0);
    cycle(4'd0, 12'd0, 1'b0, 1'b0);
    check("rstm_hold", 32'(o_grant), 32'd0);
    run_idle(500);

    // random traffic
    force_d = -1; force_len = 0;
    for (int n = 0; n < 4000; n++) begin
      cycle(($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'd0,
            12'($urandom),
            ($urandom_range(0, 59) == 0),
            ($urandom_range(0, 799) == 0));
    end
    run_idle(3000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
